inertial_fusion_cal: RTL and testbench



---
 rtl/inertial_fusion_cal_pkg.sv | 31 +++
 rtl/inertial_fusion_cal_if.sv | 43 ++++
 rtl/inertial_offset_cal.sv | 68 ++++++
 rtl/inertial_fusion_cal.sv | 122 ++++++++++++
 tb/tb_inertial_fusion_cal.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/inertial_fusion_cal_pkg.sv
// Shared definitions for the inertial fusion / calibration block.
//   state_t         : top-level mode (RUN integrates, CAL learns offsets)
//   DEF_RT_OFFSET   : power-on pitch-rate offset
//   DEF_AZ_OFFSET   : power-on Z-acceleration offset
//   sat()           : clamp a signed value to the range of a w-bit signed word
package inertial_pkg;

  typedef enum logic [0:0] {
    RUN = 1'b0,
    CAL = 1'b1
  } state_t;

  localparam logic [15:0] DEF_RT_OFFSET = 16'h03C2;
  localparam logic [15:0] DEF_AZ_OFFSET = 16'hFE80;

  // Width-generic saturation: the caller sign-extends into 64 bits, and the
  // result always fits in w bits, so the caller may truncate it back.
  function automatic logic signed [63:0] sat(input logic signed [63:0] x,
                                             input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] res;
    hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (w - 1));
    res = x;
    if (x > hi) res = hi;
    else if (x < lo) res = lo;
    return res;
  endfunction

endpackage

// File: rtl/inertial_fusion_cal_if.sv
// Bus between the inertial sensor front end and the fusion block.
//   vld        : single-cycle strobe, ptch_rt/AZ are valid only while high
//   ptch_rt    : signed raw pitch rate
//   AZ         : signed raw Z acceleration
//   cal_start  : pulse requesting a calibration run
//   ptch       : signed fused pitch
//   ptch_vld   : one-cycle pulse, ptch refreshed by a RUN sample
//   cal_done   : one-cycle pulse when calibration completes
//   cal_busy   : high while calibrating
//   state_dbg  : current mode, ptch_int_dbg: full-precision integrator
//
// Handshake: there is no ready. The block accepts every cycle in which vld is
// high; the source must not hold vld for a sample it does not want consumed.
// ptch_vld is the matching output strobe, one clock after the accepted vld.
interface inertial_fusion_cal_if
  import inertial_pkg::*;
#(
  parameter int DW = 16,
  parameter int IW = 27
);

  logic                 vld;
  logic signed [DW-1:0] ptch_rt;
  logic signed [DW-1:0] AZ;
  logic                 cal_start;
  logic signed [DW-1:0] ptch;
  logic                 ptch_vld;
  logic                 cal_done;
  logic                 cal_busy;
  state_t               state_dbg;
  logic signed [IW-1:0] ptch_int_dbg;

  modport master (
    output vld, ptch_rt, AZ, cal_start,
    input  ptch, ptch_vld, cal_done, cal_busy, state_dbg, ptch_int_dbg
  );

  modport slave (
    input  vld, ptch_rt, AZ, cal_start,
    output ptch, ptch_vld, cal_done, cal_busy, state_dbg, ptch_int_dbg
  );

endinterface

// File: rtl/inertial_offset_cal.sv
// Offset learner: averages 2^CAL_LOG2 samples of pitch rate and AZ.
//   clear   : restart the average (sums and count to zero)
//   vld     : sample strobe, already qualified by the CAL mode
//   ptch_rt : raw pitch rate, az : raw Z acceleration
//   last    : combinational, this vld is the final sample of the run
//   rt_off  : learned (or default) rate offset
//   az_off  : learned (or default) AZ offset
//   done    : registered one-cycle pulse after the final sample
module inertial_offset_cal #(
  parameter int             DW            = 16,
  parameter int             CAL_LOG2      = 8,
  parameter logic [DW-1:0]  RT_OFFSET_DEF = 16'h03C2,
  parameter logic [DW-1:0]  AZ_OFFSET_DEF = 16'hFE80
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 vld,
  input  logic signed [DW-1:0] ptch_rt,
  input  logic signed [DW-1:0] az,
  output logic                 last,
  output logic signed [DW-1:0] rt_off,
  output logic signed [DW-1:0] az_off,
  output logic                 done
);

  // CAL_LOG2 guard bits so the sum of 2^CAL_LOG2 full-scale samples cannot wrap.
  localparam int SW = DW + CAL_LOG2;

  logic signed [SW-1:0] sum_rt_q;
  logic signed [SW-1:0] sum_az_q;
  logic signed [SW-1:0] sum_rt_nxt;
  logic signed [SW-1:0] sum_az_nxt;
  logic [CAL_LOG2-1:0]  cnt_q;

  assign sum_rt_nxt = sum_rt_q + SW'(ptch_rt);
  assign sum_az_nxt = sum_az_q + SW'(az);
  assign last       = vld && (cnt_q == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_rt_q <= '0;
      sum_az_q <= '0;
      cnt_q    <= '0;
      rt_off   <= RT_OFFSET_DEF;
      az_off   <= AZ_OFFSET_DEF;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clear) begin
        sum_rt_q <= '0;
        sum_az_q <= '0;
        cnt_q    <= '0;
      end else if (vld) begin
        sum_rt_q <= sum_rt_nxt;
        sum_az_q <= sum_az_nxt;
        cnt_q    <= cnt_q + 1'b1;
        if (last) begin
          // Average includes the sample arriving this cycle.
          rt_off <= DW'(sum_rt_nxt >>> CAL_LOG2);
          az_off <= DW'(sum_az_nxt >>> CAL_LOG2);
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/inertial_fusion_cal.sv
// Complementary-filter pitch integrator with run-time offset calibration.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : sensor samples in (vld, ptch_rt, AZ, cal_start), fused pitch
//                and status out (ptch, ptch_vld, cal_done, cal_busy, debug)
// In RUN every sample integrates the offset-corrected gyro rate and nudges the
// integrator by a fixed step toward the accelerometer pitch. In CAL samples
// are averaged to relearn both offsets; the integrator restarts at zero.
module inertial_fusion_cal
  import inertial_pkg::*;
#(
  parameter int            DW            = 16,
  parameter int            FRAC          = 11,
  parameter int            ACC_GAIN      = 327,
  parameter int            ACC_SHIFT     = 13,
  parameter int            FUSION_STEP   = 1024,
  parameter int            CAL_LOG2      = 8,
  parameter logic [DW-1:0] RT_OFFSET_DEF = DEF_RT_OFFSET,
  parameter logic [DW-1:0] AZ_OFFSET_DEF = DEF_AZ_OFFSET
) (
  input logic                 clk,
  input logic                 rst_n,
  inertial_fusion_cal_if.slave bus
);

  localparam int IW = DW + FRAC;
  localparam int PW = 2 * DW;
  // Two headroom bits: ptch_int - rt_comp + step cannot overflow before clamping.
  localparam int XW = IW + 2;
  localparam logic signed [PW-1:0] GAIN_P = PW'(ACC_GAIN);
  localparam logic signed [XW-1:0] STEP_X = XW'(FUSION_STEP);

  state_t               state_q, state_d;
  logic signed [IW-1:0] ptch_int_q, ptch_int_d;
  logic                 ptch_vld_q;

  logic signed [DW-1:0] rt_off, az_off;
  logic                 cal_clear, cal_vld, cal_last, cal_done;

  logic signed [DW-1:0] rt_comp, az_comp, ptch_acc, ptch_cur;
  logic signed [PW-1:0] prod, acc_wide;
  logic signed [XW-1:0] step_x, sum_x;
  logic signed [IW-1:0] ptch_int_run;

  inertial_offset_cal #(
    .DW           (DW),
    .CAL_LOG2     (CAL_LOG2),
    .RT_OFFSET_DEF(RT_OFFSET_DEF),
    .AZ_OFFSET_DEF(AZ_OFFSET_DEF)
  ) u_cal (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (cal_clear),
    .vld    (cal_vld),
    .ptch_rt(bus.ptch_rt),
    .az     (bus.AZ),
    .last   (cal_last),
    .rt_off (rt_off),
    .az_off (az_off),
    .done   (cal_done)
  );

  // Fusion datapath for the sample currently on the bus.
  always_comb begin
    rt_comp  = bus.ptch_rt - rt_off;
    az_comp  = bus.AZ - az_off;
    prod     = PW'(az_comp) * GAIN_P;
    acc_wide = prod >>> ACC_SHIFT;
    ptch_acc = DW'(sat(64'(acc_wide), DW));
    ptch_cur = ptch_int_q[IW-1:FRAC];
    if (ptch_acc > ptch_cur)      step_x = STEP_X;
    else if (ptch_acc < ptch_cur) step_x = -STEP_X;
    else                          step_x = '0;
    // Gyro rate is subtracted: positive rate means pitch decreasing.
    sum_x        = XW'(ptch_int_q) - XW'(rt_comp) + step_x;
    ptch_int_run = IW'(sat(64'(sum_x), IW));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      ptch_int_q <= '0;
      ptch_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptch_int_q <= ptch_int_d;
      ptch_vld_q <= (state_q == RUN) && bus.vld;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptch_int_d = ptch_int_q;
    cal_clear  = 1'b0;
    cal_vld    = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.vld) ptch_int_d = ptch_int_run;
        // A sample coinciding with cal_start is still integrated.
        if (bus.cal_start) begin
          state_d   = CAL;
          cal_clear = 1'b1;
        end
      end
      CAL: begin
        cal_vld = bus.vld;
        if (cal_last) begin
          state_d    = RUN;
          ptch_int_d = '0;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign bus.ptch         = ptch_int_q[IW-1:FRAC];
  assign bus.ptch_vld     = ptch_vld_q;
  assign bus.cal_done     = cal_done;
  assign bus.cal_busy     = (state_q == CAL);
  assign bus.state_dbg    = state_q;
  assign bus.ptch_int_dbg = ptch_int_q;

endmodule

// File: tb/tb_inertial_fusion_cal.sv
// Bench for inertial_fusion_cal: vector table, calibration and reset
// sequences, then randomized traffic against an arithmetic reference model.
module tb_inertial_fusion_cal;
  import inertial_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  inertial_fusion_cal_if #(.DW(16), .IW(27)) bus();

  inertial_fusion_cal dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_err    = 0;
  int done_seen = 0;

  // ---------------- reference model ----------------
  longint m_int, m_rt_off, m_az_off, m_sum_rt, m_sum_az;
  int     m_cnt;
  bit     m_cal;
  logic [15:0] exp_q[$];

  function automatic longint s16(input longint x);
    logic signed [15:0] t;
    t = x[15:0];
    return longint'(t);
  endfunction

  function automatic longint clamp(input longint x, input longint lo, input longint hi);
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  task automatic model_reset();
    m_int    = 0;
    m_rt_off = s16(64'h03C2);
    m_az_off = s16(64'hFE80);
    m_sum_rt = 0;
    m_sum_az = 0;
    m_cnt    = 0;
    m_cal    = 0;
    exp_q.delete();
  endtask

  // One clock of behaviour given this cycle's inputs.
  task automatic model_cycle(input bit v, input logic [15:0] rt, input logic [15:0] az,
                             input bit cs, output bit e_vld, output bit e_done);
    longint rc, ac, acc, p, st;
    e_vld  = 0;
    e_done = 0;
    if (!m_cal) begin
      if (v) begin
        rc  = s16(s16(longint'(rt)) - m_rt_off);
        ac  = s16(s16(longint'(az)) - m_az_off);
        acc = clamp((ac * 327) >>> 13, -32768, 32767);
        p   = m_int >>> 11;
        st  = (acc > p) ? 1024 : ((acc < p) ? -1024 : 0);
        m_int = clamp(m_int - rc + st, -(longint'(1) << 26), (longint'(1) << 26) - 1);
        e_vld = 1;
      end
      if (cs) begin
        m_cal = 1; m_cnt = 0; m_sum_rt = 0; m_sum_az = 0;
      end
    end else if (v) begin
      m_sum_rt += s16(longint'(rt));
      m_sum_az += s16(longint'(az));
      m_cnt++;
      if (m_cnt == 256) begin
        m_rt_off = s16(m_sum_rt >>> 8);
        m_az_off = s16(m_sum_az >>> 8);
        m_int    = 0;
        m_cal    = 0;
        e_done   = 1;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge: drive inputs, let one rising edge pass, then
  // compare at the next falling edge.
  task automatic cyc(input bit v, input logic [15:0] rt, input logic [15:0] az, input bit cs);
    bit ev, ed;
    logic [15:0] ep;
    bus.vld       = v;
    bus.ptch_rt   = rt;
    bus.AZ        = az;
    bus.cal_start = cs;
    @(negedge clk);
    model_cycle(v, rt, az, cs, ev, ed);
    exp_q.push_back(16'(m_int >>> 11));
    if (bus.cal_done) done_seen++;
    check("ptch_int", longint'(bus.ptch_int_dbg), m_int);
    ep = exp_q.pop_front();
    check("ptch", longint'(bus.ptch), s16(longint'(ep)));
    check("ptch_vld", longint'(bus.ptch_vld), longint'(ev));
    check("cal_done", longint'(bus.cal_done), longint'(ed));
    check("cal_busy", longint'(bus.cal_busy), longint'(m_cal));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ptch"},     longint'(bus.ptch), 0);
    check({tag, "_ptch_vld"}, longint'(bus.ptch_vld), 0);
    check({tag, "_cal_done"}, longint'(bus.cal_done), 0);
    check({tag, "_cal_busy"}, longint'(bus.cal_busy), 0);
    check({tag, "_ptch_int"}, longint'(bus.ptch_int_dbg), 0);
    check({tag, "_state"},    longint'(bus.state_dbg), longint'(RUN));
  endtask

  // Assert reset between clock edges and check the outputs clear immediately.
  task automatic async_reset(input string tag);
    #2;
    rst_n         = 1'b0;
    bus.vld       = 1'b0;
    bus.cal_start = 1'b0;
    #1;
    check_reset_outputs(tag);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic [15:0] rt;
    logic [15:0] az;
    int          n;
    int          gap;
    longint      exp_int;
    longint      exp_ptch;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{"gyro",      16'hFBC2, 16'hFE80, 4,    0, 5120,     2};
    vecs[1] = '{"accel",     16'h03C2, 16'h0268, 2,    0, 2048,     1};
    vecs[2] = '{"deadband",  16'h03C2, 16'hFE80, 100,  1, 0,        0};
    vecs[3] = '{"saturate",  16'h83C2, 16'hFE80, 4096, 0, 67108863, 32767};

    rst_n         = 1'b0;
    bus.vld       = 1'b0;
    bus.ptch_rt   = '0;
    bus.AZ        = '0;
    bus.cal_start = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        cyc(1'b1, vecs[i].rt, vecs[i].az, 1'b0);
        for (int g = 0; g < vecs[i].gap; g++) cyc(1'b0, vecs[i].rt, vecs[i].az, 1'b0);
      end
      check({vecs[i].name, "_final_int"},  longint'(bus.ptch_int_dbg), vecs[i].exp_int);
      check({vecs[i].name, "_final_ptch"}, longint'(bus.ptch), vecs[i].exp_ptch);
      async_reset({vecs[i].name, "_rst"});
    end

    // Calibration run, with an extra cal_start mid-run that must be ignored.
    done_seen = 0;
    cyc(1'b0, 16'h0400, 16'hFF00, 1'b1);
    for (int k = 0; k < 256; k++) begin
      cyc(1'b1, 16'h0400, 16'hFF00, k == 50);
      if (k < 255) check("cal_busy_run", longint'(bus.cal_busy), 1);
    end
    check("cal_done_after_last", longint'(bus.cal_done), 1);
    check("cal_busy_after_last", longint'(bus.cal_busy), 0);
    repeat (3) cyc(1'b0, 16'h0400, 16'hFF00, 1'b0);
    check("cal_done_count", longint'(done_seen), 1);
    check("rt_off_learned", longint'(dut.rt_off), longint'(16'sh0400));
    check("az_off_learned", longint'(dut.az_off), -256);
    for (int k = 0; k < 20; k++) cyc(1'b1, 16'h0400, 16'hFF00, 1'b0);
    check("cal_hold_int", longint'(bus.ptch_int_dbg), 0);

    // Reset after 100 calibration samples restores defaults.
    cyc(1'b0, 16'h0400, 16'hFF00, 1'b1);
    for (int k = 0; k < 100; k++) cyc(1'b1, 16'h0400, 16'hFF00, 1'b0);
    async_reset("cal_abort");
    check("rt_off_default", longint'(dut.rt_off), 962);
    check("az_off_default", longint'(dut.az_off), -384);
    cyc(1'b1, 16'hFBC2, 16'hFE80, 1'b0);
    check("post_abort_int", longint'(bus.ptch_int_dbg), 2048);

    // Randomized traffic around the live offsets, with occasional full-range
    // samples and calibration requests.
    for (int k = 0; k < 3000; k++) begin
      logic [15:0] rt, az;
      bit v, cs;
      v  = ($urandom_range(0, 1) == 1);
      cs = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0) rt = 16'($urandom);
      else rt = 16'(m_rt_off + longint'($urandom_range(0, 4000)) - 2000);
      if ($urandom_range(0, 3) == 0) az = 16'($urandom);
      else az = 16'(m_az_off + longint'($urandom_range(0, 6000)) - 3000);
      cyc(v, rt, az, cs);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
